// File: rtl/channel_mux_pkg.sv
// rtl/channel_mux_pkg.sv - shared sample width, idle words and underflow counter for channel_mux/channel_demux
package channel_mux_pkg;

  localparam int              ADC_RES_DEF = 14;
  localparam logic [13:0]     IDLE_A_DEF  = 14'h0;
  localparam logic [13:0]     IDLE_B_DEF  = 14'h0;
  localparam int              UNDERFLOW_W = 16;
  localparam logic [UNDERFLOW_W-1:0] UNDERFLOW_MAX = '1;

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  function automatic logic [UNDERFLOW_W-1:0] sat_inc(input logic [UNDERFLOW_W-1:0] v);
    return (v == UNDERFLOW_MAX) ? v : v + UNDERFLOW_W'(1);
  endfunction

endpackage

// File: rtl/ODDR.sv
// rtl/ODDR.sv - behavioural model of the output DDR primitive used by oddr_bus
module ODDR #(
  parameter DDR_CLK_EDGE = "SAME_EDGE"
) (
  output logic Q,
  input  logic C,
  input  logic CE,
  input  logic D1,
  input  logic D2,
  input  logic R,
  input  logic S
);

  logic q_rise;
  logic q_fall;

  always_ff @(posedge C) begin
    if (R)       q_rise <= 1'b0;
    else if (S)  q_rise <= 1'b1;
    else if (CE) q_rise <= D1;
  end

  // SAME_EDGE captures both halves on the rising edge; D2 then shows while C is low
  generate
    if (DDR_CLK_EDGE == "OPPOSITE_EDGE") begin : g_opposite
      always_ff @(negedge C) begin
        if (R)       q_fall <= 1'b0;
        else if (S)  q_fall <= 1'b1;
        else if (CE) q_fall <= D2;
      end
    end else begin : g_same
      always_ff @(posedge C) begin
        if (R)       q_fall <= 1'b0;
        else if (S)  q_fall <= 1'b1;
        else if (CE) q_fall <= D2;
      end
    end
  endgenerate

  assign Q = C ? q_rise : q_fall;

endmodule

// File: rtl/channel_mux_oddr_bus.sv
// rtl/channel_mux_oddr_bus.sv - one ODDR per bit: d1 drives the high half, d2 the low half
module oddr_bus
  import channel_mux_pkg::*;
#(
  parameter int Width = ADC_RES_DEF
) (
  input  logic             clk,
  input  logic [Width-1:0] d1,
  input  logic [Width-1:0] d2,
  output logic [Width-1:0] q
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    ODDR #(
      .DDR_CLK_EDGE("SAME_EDGE")
    ) u_oddr (
      .Q (q[i]),
      .C (clk),
      .CE(1'b1),
      .D1(d1[i]),
      .D2(d2[i]),
      .R (1'b0),
      .S (1'b0)
    );
  end

endmodule

// File: rtl/channel_mux.sv
// rtl/channel_mux.sv - buffers A/B sample pairs and drives them interleaved on a DDR DAC bus
module channel_mux
  import channel_mux_pkg::*;
#(
  parameter int                AdcRes    = ADC_RES_DEF,
  parameter int                FifoDepth = 4,
  parameter logic [AdcRes-1:0] IdleA     = AdcRes'(IDLE_A_DEF),
  parameter logic [AdcRes-1:0] IdleB     = AdcRes'(IDLE_B_DEF)
) (
  input  logic                   clk_mux_i,
  input  logic                   rst_n_i,
  input  logic                   tx_en_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [AdcRes-1:0]      ch_A_i,
  input  logic [AdcRes-1:0]      ch_B_i,
  output logic [AdcRes-1:0]      dac_data_o,
  output logic                   tx_valid_o,
  output logic [UNDERFLOW_W-1:0] underflow_cnt_o
);

  localparam int              PtrW = $clog2(FifoDepth);
  localparam int              CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FifoDepth);

  logic [AdcRes-1:0] fifo_a [FifoDepth];
  logic [AdcRes-1:0] fifo_b [FifoDepth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_next;
  logic              push;
  logic              pop;
  logic              empty;
  logic [AdcRes-1:0] d1_q;
  logic [AdcRes-1:0] d2_q;
  logic              d_valid_q;

  assign empty = (count == '0);
  assign push  = s_valid_i & s_ready_o;
  assign pop   = tx_en_i & ~empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CntW'(1);
      2'b01:   count_next = count - CntW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_mux_i) begin
    if (push) begin
      fifo_a[wr_ptr] <= ch_A_i;
      fifo_b[wr_ptr] <= ch_B_i;
    end
  end

  // ready comes from the next count so it never depends combinationally on the pop
  always_ff @(posedge clk_mux_i) begin
    if (!rst_n_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      s_ready_o       <= 1'b0;
      d1_q            <= IdleA;
      d2_q            <= IdleB;
      d_valid_q       <= 1'b0;
      tx_valid_o      <= 1'b0;
      underflow_cnt_o <= '0;
    end else begin
      count      <= count_next;
      s_ready_o  <= (count_next < Full);
      tx_valid_o <= d_valid_q;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop) begin
        d1_q      <= fifo_a[rd_ptr];
        d2_q      <= fifo_b[rd_ptr];
        d_valid_q <= 1'b1;
        rd_ptr    <= rd_ptr + PtrW'(1);
      end else begin
        d1_q      <= IdleA;
        d2_q      <= IdleB;
        d_valid_q <= 1'b0;
        if (tx_en_i) underflow_cnt_o <= sat_inc(underflow_cnt_o);
      end
    end
  end

  oddr_bus #(
    .Width(AdcRes)
  ) u_oddr_bus (
    .clk(clk_mux_i),
    .d1 (d1_q),
    .d2 (d2_q),
    .q  (dac_data_o)
  );

endmodule

// File: tb/tb_channel_mux.sv
// tb/tb_channel_mux.sv - self-checking bench for channel_mux against a queue-based reference
module tb_channel_mux;

  localparam int             AW     = 14;
  localparam int             DEPTH  = 4;
  localparam logic [AW-1:0]  IDLE_A = 14'h155;
  localparam logic [AW-1:0]  IDLE_B = 14'h2AA;
  localparam int             UF_MAX = 65535;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          tx_en   = 1'b0;
  logic          s_valid = 1'b0;
  logic [AW-1:0] ch_a    = '0;
  logic [AW-1:0] ch_b    = '0;
  logic          s_ready;
  logic          tx_valid;
  logic [AW-1:0] dac_data;
  logic [15:0]   uf_cnt;

  int errors = 0;
  int checks = 0;

  channel_mux #(
    .AdcRes(AW), .FifoDepth(DEPTH), .IdleA(IDLE_A), .IdleB(IDLE_B)
  ) dut (
    .clk_mux_i      (clk),
    .rst_n_i        (rst_n),
    .tx_en_i        (tx_en),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .ch_A_i         (ch_a),
    .ch_B_i         (ch_b),
    .dac_data_o     (dac_data),
    .tx_valid_o     (tx_valid),
    .underflow_cnt_o(uf_cnt)
  );

  always #5 clk = ~clk;

  // Reference: pairs wait in a queue; a popped pair reaches the bus one edge after it leaves
  logic [2*AW-1:0] mq[$];
  logic            m_ready   = 1'b0;
  logic            st1_valid = 1'b0;
  logic [AW-1:0]   st1_a     = IDLE_A;
  logic [AW-1:0]   st1_b     = IDLE_B;
  int              m_uf      = 0;
  logic            exp_valid;
  logic [AW-1:0]   exp_a, exp_b;
  logic            accepted;
  logic [AW-1:0]   obs_a, obs_b;
  logic            obs_valid, obs_ready;
  logic [15:0]     obs_uf;
  logic [2*AW-1:0] pairs [5];
  int              fill_idx;

  task automatic tick();
    logic do_push, do_pop, was_empty;
    logic [2*AW-1:0] pair;
    was_empty = (mq.size() == 0);
    do_push   = rst_n && s_valid && m_ready;
    do_pop    = rst_n && tx_en && !was_empty;
    accepted  = do_push;
    @(posedge clk);
    exp_a     = st1_a;
    exp_b     = st1_b;
    exp_valid = rst_n && st1_valid;
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0; m_uf = 0;
      st1_valid = 1'b0; st1_a = IDLE_A; st1_b = IDLE_B;
    end else begin
      if (do_pop) begin
        pair = mq.pop_front();
        {st1_a, st1_b} = pair;
        st1_valid = 1'b1;
      end else begin
        st1_valid = 1'b0; st1_a = IDLE_A; st1_b = IDLE_B;
        if (tx_en && was_empty && m_uf < UF_MAX) m_uf++;
      end
      if (do_push) mq.push_back({ch_a, ch_b});
      m_ready = (mq.size() < DEPTH);
    end
    #1;
    obs_a = dac_data; obs_valid = tx_valid; obs_ready = s_ready; obs_uf = uf_cnt;
    @(negedge clk);
    #1;
    obs_b = dac_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_en = 1'b0; s_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_en = 1'b0; s_valid = 1'b0;
    tick(); tick();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", obs_ready); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", obs_valid); end
    checks++; if (obs_uf !== 16'h0) begin errors++; $display("FAIL reset_uf got=%h required=0000", obs_uf); end
    checks++; if (obs_a !== IDLE_A || obs_b !== IDLE_B) begin
      errors++; $display("FAIL reset_bus got=%h/%h required=%h/%h", obs_a, obs_b, IDLE_A, IDLE_B);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b required=1", obs_ready); end
  endtask

  task automatic test_single();
    int nvalid = 0;
    do_reset();
    tx_en = 1'b1; s_valid = 1'b1; ch_a = 14'h0123; ch_b = 14'h3210;
    tick();
    s_valid = 1'b0;
    checks++; if (!accepted || obs_valid !== 1'b0) begin errors++; $display("FAIL single_push acc=%b valid=%b required 1/0", accepted, obs_valid); end
    tick();
    checks++; if (obs_valid !== 1'b0 || obs_a !== IDLE_A || obs_b !== IDLE_B) begin
      errors++; $display("FAIL single_k1 got v=%b %h/%h required v=0 %h/%h", obs_valid, obs_a, obs_b, IDLE_A, IDLE_B);
    end
    tick();
    checks++; if (obs_valid !== 1'b1 || obs_a !== 14'h0123 || obs_b !== 14'h3210) begin
      errors++; $display("FAIL single_k2 got v=%b %h/%h required v=1 0123/3210", obs_valid, obs_a, obs_b);
    end
    if (obs_valid === 1'b1) nvalid++;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (obs_valid === 1'b1) nvalid++;
      checks++; if (obs_a !== IDLE_A || obs_b !== IDLE_B) begin
        errors++; $display("FAIL single_after t=%0d got %h/%h required %h/%h", t, obs_a, obs_b, IDLE_A, IDLE_B);
      end
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d required=1", nvalid); end
    tx_en = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 5; i++) pairs[i] = {AW'($urandom), AW'($urandom)};
    fill_idx = 0; tx_en = 1'b0; s_valid = 1'b1; {ch_a, ch_b} = pairs[0];
    for (int t = 0; t < 8; t++) begin
      tick();
      if (accepted) begin
        fill_idx++;
        if (fill_idx < 5) {ch_a, ch_b} = pairs[fill_idx];
      end
      checks++; if (obs_valid !== 1'b0 || obs_a !== IDLE_A || obs_b !== IDLE_B) begin
        errors++; $display("FAIL fill_idle t=%0d got v=%b %h/%h required v=0 %h/%h", t, obs_valid, obs_a, obs_b, IDLE_A, IDLE_B);
      end
      checks++; if (obs_uf !== 16'h0) begin errors++; $display("FAIL fill_uf t=%0d got=%h required=0000", t, obs_uf); end
      checks++; if (obs_ready !== 1'(fill_idx < DEPTH)) begin
        errors++; $display("FAIL fill_ready t=%0d got=%b required=%b", t, obs_ready, 1'(fill_idx < DEPTH));
      end
    end
    checks++; if (fill_idx != DEPTH) begin errors++; $display("FAIL fill_count got=%0d required=%0d", fill_idx, DEPTH); end
  endtask

  task automatic test_drain();
    int outs = 0, first = -1, last = -1;
    tx_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (accepted) begin
        fill_idx++;
        if (fill_idx < 5) {ch_a, ch_b} = pairs[fill_idx];
        else s_valid = 1'b0;
      end
      if (obs_valid === 1'b1) begin
        checks++;
        if (outs >= 5) begin
          errors++; $display("FAIL drain_extra t=%0d got %h/%h required no more data", t, obs_a, obs_b);
        end else if ({obs_a, obs_b} !== pairs[outs]) begin
          errors++; $display("FAIL drain_data n=%0d got %h/%h required %h", outs, obs_a, obs_b, pairs[outs]);
        end
        if (first < 0) first = t;
        last = t;
        outs++;
      end
    end
    checks++; if (outs != 5) begin errors++; $display("FAIL drain_outs got=%0d required=5", outs); end
    checks++; if (last - first != 4) begin errors++; $display("FAIL drain_gap span got=%0d required=4", last - first); end
    s_valid = 1'b0; tx_en = 1'b0;
  endtask

  task automatic test_stream();
    logic [AW-1:0] nxt, want;
    int outs = 0;
    bit seen = 0;
    do_reset();
    nxt = AW'($urandom); want = nxt;
    tx_en = 1'b0; s_valid = 1'b1; ch_a = nxt; ch_b = ~nxt;
    tick();
    if (accepted) begin nxt = nxt + 1'b1; ch_a = nxt; ch_b = ~nxt; end
    tx_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (accepted) begin nxt = nxt + 1'b1; ch_a = nxt; ch_b = ~nxt; end
      if (seen || obs_valid === 1'b1) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_a !== want || obs_b !== ~want) begin
          errors++; $display("FAIL stream_data i=%0d got v=%b %h/%h required v=1 %h/%h", i, obs_valid, obs_a, obs_b, want, ~want);
        end
        seen = 1; want = want + 1'b1; outs++;
      end
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b required=1", i, obs_ready); end
    end
    checks++; if (outs != 999) begin errors++; $display("FAIL stream_outs got=%0d required=999", outs); end
    checks++; if (obs_uf !== 16'h0) begin errors++; $display("FAIL stream_uf got=%h required=0000", obs_uf); end
    s_valid = 1'b0; tx_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      tx_en   = ($urandom_range(0, 9) < 7);
      s_valid = ($urandom_range(0, 3) != 0);
      ch_a    = AW'($urandom);
      ch_b    = AW'($urandom);
      tick();
      checks++; if (obs_a !== exp_a || obs_b !== exp_b) begin
        errors++; $display("FAIL rand_bus i=%0d got %h/%h required %h/%h", i, obs_a, obs_b, exp_a, exp_b);
      end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rand_valid i=%0d got=%b required=%b", i, obs_valid, exp_valid); end
      checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL rand_ready i=%0d got=%b required=%b", i, obs_ready, m_ready); end
      checks++; if (obs_uf !== 16'(m_uf)) begin errors++; $display("FAIL rand_uf i=%0d got=%0d required=%0d", i, obs_uf, m_uf); end
    end
    rst_n = 1'b1; s_valid = 1'b0; tx_en = 1'b0;
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    tx_en = 1'b1; s_valid = 1'b0;
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (n == 65534 || n == 65535 || n == 65536 || n == 70000) begin
        want = (n < UF_MAX) ? n : UF_MAX;
        checks++; if (obs_uf !== 16'(want)) begin
          errors++; $display("FAIL uf_sat n=%0d got=%h required=%h", n, obs_uf, 16'(want));
        end
      end
    end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL uf_valid got=%b required=0", obs_valid); end
    tx_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    do_reset();
    tx_en = 1'b0; s_valid = 1'b1; ch_a = 14'h3A00; ch_b = 14'h0A50;
    for (int t = 0; t < 6 && cnt < 3; t++) begin
      tick();
      if (accepted) begin
        cnt++;
        ch_a = AW'(14'h3A00 + cnt); ch_b = AW'(14'h0A50 + cnt);
      end
    end
    s_valid = 1'b0;
    checks++; if (cnt != 3) begin errors++; $display("FAIL rmid_buffered got=%0d required=3", cnt); end
    rst_n = 1'b0;
    tick();
    checks++; if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_reset got rdy=%b v=%b required 0/0", obs_ready, obs_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (obs_a !== IDLE_A || obs_b !== IDLE_B) begin
      errors++; $display("FAIL rmid_idle got %h/%h required %h/%h", obs_a, obs_b, IDLE_A, IDLE_B);
    end
    tx_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++; if (obs_valid !== 1'b0 || obs_a !== IDLE_A || obs_b !== IDLE_B || obs_ready !== 1'b1) begin
        errors++; $display("FAIL rmid_after t=%0d got v=%b rdy=%b %h/%h required v=0 rdy=1 %h/%h",
                           t, obs_valid, obs_ready, obs_a, obs_b, IDLE_A, IDLE_B);
      end
    end
    tx_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
